// File: rtl/subseq_frame_feeder.sv
`timescale 1ns/1ps
// Frame feeder for the maximum-subsequence-sum block.
// Buffers 8 signed samples from a stalling source. It then replays them as one
// gap-free 8-cycle burst on valid_in/data_in. It then waits for the sum block's
// valid_out (sum_valid) before it accepts the next frame. A WAIT that runs for
// TIMEOUT cycles gives up on the frame and raises a sticky timeout_err.
module subseq_frame_feeder #(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic       valid_in,
  output logic [7:0] data_in,
  input  logic       sum_valid,
  output logic [7:0] frame_cnt,
  output logic       timeout_err
);

  localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_BURST = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [2:0]    wr_idx;
  logic [3:0]    rd_idx;      // 0..7 replay samples, 8 closes the burst
  logic [WW-1:0] wait_cnt;
  logic [7:0]    mem [8];
  logic          handshake;
  logic          burst_done;
  logic          wait_expired;

  assign s_ready      = (state == S_FILL);
  assign handshake    = s_valid & s_ready;
  assign burst_done   = rd_idx[3];
  assign wait_expired = (wait_cnt == WAIT_LAST);

  // State register.
  // NOTE: every clocked block uses non-blocking assignments so all flops update
  // together from pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FILL;
    else      state <= state_next;
  end

  // Next-state decode; sum_valid has priority over the wait timeout.
  // NOTE: state_next gets a default before the case, so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_FILL:  if (handshake && wr_idx == 3'd7) state_next = S_BURST;
      S_BURST: if (burst_done)                  state_next = S_WAIT;
      S_WAIT:  if (sum_valid || wait_expired)   state_next = S_FILL;
      default:                                  state_next = S_FILL;
    endcase
  end

  // Sample storage, written in arrival order and passed through untouched.
  // NOTE: the buffer has no reset. A new frame overwrites it completely before
  // any of it is read, so clearing it would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (handshake) mem[wr_idx] <= s_data;
  end

  // Write pointer: advances on each accepted sample and wraps to 0 after the 8th.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           wr_idx <= '0;
    else if (handshake) wr_idx <= wr_idx + 3'd1;
  end

  // Burst replay: eight registered beats, then one closing edge that drops valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_idx   <= '0;
      valid_in <= 1'b0;
      data_in  <= '0;
    end else if (state == S_BURST && !burst_done) begin
      rd_idx   <= rd_idx + 4'd1;
      valid_in <= 1'b1;
      data_in  <= mem[rd_idx[2:0]];
    end else begin
      rd_idx   <= '0;
      valid_in <= 1'b0;
      data_in  <= '0;
    end
  end

  // Frame counter: counts each completed burst and wraps modulo 256.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 frame_cnt <= '0;
    else if (state == S_BURST && burst_done) frame_cnt <= frame_cnt + 8'd1;
  end

  // Wait counter: cleared while not waiting, counts each edge spent in WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  wait_cnt <= '0;
    else if (state == S_WAIT) wait_cnt <= wait_cnt + WW'(1);
    else                       wait_cnt <= '0;
  end

  // Sticky timeout flag. Only reset clears it, and a coincident sum_valid suppresses it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      timeout_err <= 1'b0;
    else if (state == S_WAIT && wait_expired && !sum_valid)
      timeout_err <= 1'b1;
  end

endmodule

// File: tb/tb_subseq_frame_feeder.sv
`timescale 1ns/1ps
// Directed testbench for subseq_frame_feeder.
module tb_subseq_frame_feeder;

  localparam int TIMEOUT = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       valid_in;
  logic [7:0] data_in;
  logic       sum_valid;
  logic [7:0] frame_cnt;
  logic       timeout_err;

  int         checks = 0;
  int         errors = 0;
  int         exp_cnt = 0;
  logic [7:0] smp [8];
  int         gap [8];
  logic [7:0] got [8];

  subseq_frame_feeder #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .sum_valid  (sum_valid),
    .frame_cnt  (frame_cnt),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Kadane over the captured burst, as the downstream sum block would compute it.
  function automatic int max_sub();
    int best = -1000;
    int cur  = 0;
    for (int i = 0; i < 8; i++) begin
      cur  = (cur + int'($signed(got[i])) > int'($signed(got[i]))) ?
             cur + int'($signed(got[i])) : int'($signed(got[i]));
      best = (cur > best) ? cur : best;
    end
    return best;
  endfunction

  // Feed smp[] with gap[] idle cycles, then check the burst and the WAIT entry.
  // hold99 keeps s_valid high with 99 after the frame.
  // poke_sv pulses sum_valid in FILL and in BURST, where it must be ignored.
  task automatic run_frame(input bit hold99, input bit poke_sv);
    for (int j = 0; j < 8; j++) begin
      for (int g = 0; g < gap[j]; g++) begin
        s_valid   = 1'b0;
        sum_valid = (poke_sv && j == 0 && g == 0);
        tick();
      end
      sum_valid = 1'b0;
      chk("s_ready_fill", s_ready, 1);
      s_valid = 1'b1;
      s_data  = smp[j];
      tick();
    end
    if (hold99) s_data = 8'd99;
    else        s_valid = 1'b0;
    chk("burst_not_yet", valid_in, 0);
    chk("s_ready_burst", s_ready, 0);
    for (int j = 0; j < 8; j++) begin
      sum_valid = (poke_sv && j == 0);
      tick();
      sum_valid = 1'b0;
      chk("burst_valid", valid_in, 1);
      chk("burst_data", data_in, smp[j]);
      got[j] = data_in;
    end
    tick();
    exp_cnt = (exp_cnt + 1) % 256;
    chk("wait_valid", valid_in, 0);
    chk("wait_data", data_in, 0);
    chk("frame_cnt", frame_cnt, exp_cnt);
    chk("s_ready_wait", s_ready, 0);
  endtask

  // Stay in WAIT for n more cycles, then return sum_valid and expect FILL.
  task automatic release_wait(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("wait_hold", s_ready, 0);
      chk("wait_idle", valid_in, 0);
    end
    sum_valid = 1'b1;
    s_valid   = 1'b0;
    tick();
    sum_valid = 1'b0;
    chk("s_ready_after_sv", s_ready, 1);
  endtask

  initial begin
    rst = 1'b0; s_valid = 1'b0; s_data = '0; sum_valid = 1'b0;
    foreach (gap[i]) gap[i] = 0;

    // Reset values.
    #12;
    chk("rst_valid_in", valid_in, 0);
    chk("rst_data_in", data_in, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_timeout", timeout_err, 0);
    @(posedge clk); #1 rst = 1'b1;
    chk("rst_s_ready", s_ready, 1);

    // Back-to-back frame; the downstream maximum subsequence sum is 5.
    smp[0] = 8'(-7); smp[1] = 8'(1);  smp[2] = 8'(-3); smp[3] = 8'(2);
    smp[4] = 8'(-1); smp[5] = 8'(1);  smp[6] = 8'(3);  smp[7] = 8'(-5);
    run_frame(1'b0, 1'b0);
    chk("max_sum", 32'(max_sub()), 5);
    release_wait(3);

    // Same samples with idle gaps, stray sum_valid pulses and s_valid held at 99.
    gap[0] = 2; gap[1] = 0; gap[2] = 3; gap[3] = 1;
    gap[4] = 0; gap[5] = 2; gap[6] = 1; gap[7] = 3;
    run_frame(1'b1, 1'b1);
    release_wait(5);
    foreach (gap[i]) gap[i] = 0;

    // The next frame must line up at buf[0]; a stray 99 would show up here.
    smp[0] = 8'd10; smp[1] = 8'd20; smp[2] = 8'd30; smp[3] = 8'd40;
    smp[4] = 8'd50; smp[5] = 8'd60; smp[6] = 8'd70; smp[7] = 8'd80;
    run_frame(1'b0, 1'b0);
    // sum_valid in the last allowed WAIT cycle must win over the timeout.
    release_wait(TIMEOUT - 1);
    chk("tmo_coincident", timeout_err, 0);

    // sum_valid never returns: timeout after exactly TIMEOUT WAIT cycles.
    run_frame(1'b0, 1'b0);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    chk("tmo_last_cycle_ready", s_ready, 0);
    chk("tmo_not_early", timeout_err, 0);
    tick();
    chk("tmo_set", timeout_err, 1);
    chk("tmo_s_ready", s_ready, 1);
    tick();
    chk("tmo_sticky", timeout_err, 1);

    // Reset after the 5th handshake discards the partial frame.
    smp[0] = 8'd1; smp[1] = 8'd2; smp[2] = 8'd3; smp[3] = 8'd4; smp[4] = 8'd5;
    for (int j = 0; j < 5; j++) begin
      s_valid = 1'b1; s_data = smp[j];
      tick();
    end
    s_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_valid_in", valid_in, 0);
    chk("arst_data_in", data_in, 0);
    chk("arst_frame_cnt", frame_cnt, 0);
    chk("arst_timeout", timeout_err, 0);
    #1 rst = 1'b1;
    exp_cnt = 0;
    smp[0] = 8'd127; smp[1] = 8'h80; smp[2] = 8'd0; smp[3] = 8'd0;
    smp[4] = 8'd0;   smp[5] = 8'd0;  smp[6] = 8'd0; smp[7] = 8'd0;
    run_frame(1'b0, 1'b0);
    release_wait(0);

    // Reset in the middle of a burst: no more valid_in until a new frame arrives.
    for (int j = 0; j < 8; j++) begin
      s_valid = 1'b1; s_data = 8'(j + 1);
      tick();
    end
    s_valid = 1'b0;
    tick(); tick(); tick();
    chk("mid_burst_valid", valid_in, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_burst_rst_valid", valid_in, 0);
    chk("mid_burst_rst_cnt", frame_cnt, 0);
    #1 rst = 1'b1;
    exp_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("post_rst_quiet", valid_in, 0);
    end
    chk("post_rst_ready", s_ready, 1);

    // 256 complete frames: the frame counter wraps back to 0.
    for (int f = 0; f < 256; f++) begin
      for (int j = 0; j < 8; j++) smp[j] = 8'(f * 13 + j * 29 + 7);
      run_frame(1'b0, 1'b0);
      release_wait(f % 3);
    end
    chk("frame_cnt_wrap", frame_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
